// File: rtl/rock_pkg.sv
// Shared types, constants and parameter defaults for the rocking-motor controller.
package rock_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ROCK      = 2'd1,
    RAMP_DOWN = 2'd2
  } rockState_t;

  localparam logic [2:0] SPEED_MAX = 3'd7;

  localparam int EVAL_CYCLES_DEF   = 16;
  localparam int START_LVL_DEF     = 3;
  localparam int START_SPEED_DEF   = 2;
  localparam int GOOD_MIN_DEF      = 2;
  localparam int CALM_WINDOWS_DEF  = 3;
  localparam int ALARM_WINDOWS_DEF = 4;

  function automatic logic [3:0] satInc4(input logic [3:0] value);
    if (value == 4'd15) begin
      return 4'd15;
    end else begin
      return value + 4'd1;
    end
  endfunction

endpackage

// File: rtl/eval_timer.sv
// Evaluation window counter plus saturating decrease-pulse counter.
// pulseTotal already includes a pulse arriving in the current cycle.
module eval_timer
  import rock_pkg::*;
#(
  parameter int EVAL_CYCLES = EVAL_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       r,
  input  logic       clear,
  input  logic       stressDaalt,
  output logic       windowEnd,
  output logic [3:0] pulseTotal
);

  localparam int CW = $clog2(EVAL_CYCLES);
  localparam logic [CW-1:0] WIN_LAST = CW'(EVAL_CYCLES - 1);

  logic [CW-1:0] winCnt;
  logic [3:0]    pulseCnt;

  assign windowEnd = (winCnt == WIN_LAST);

  // Pulse total of the running window including this cycle's flag.
  always_comb begin
    pulseTotal = pulseCnt;
    if (stressDaalt) begin
      pulseTotal = satInc4(pulseCnt);
    end else begin
      pulseTotal = pulseCnt;
    end
  end

  // Window and pulse counters; both restart at every window end.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      winCnt   <= {CW{1'b0}};
      pulseCnt <= 4'd0;
    end else if (clear || windowEnd) begin
      winCnt   <= {CW{1'b0}};
      pulseCnt <= 4'd0;
    end else begin
      winCnt   <= winCnt + CW'(1);
      pulseCnt <= pulseTotal;
    end
  end

endmodule

// File: rtl/rock_controller.sv
// Rocking-motor controller: windowed evaluation of cry level and stress
// decrease pulses driving a 3-bit rocking speed and a latched no-relief alarm.
module rock_controller
  import rock_pkg::*;
#(
  parameter int EVAL_CYCLES   = EVAL_CYCLES_DEF,
  parameter int START_LVL     = START_LVL_DEF,
  parameter int START_SPEED   = START_SPEED_DEF,
  parameter int GOOD_MIN      = GOOD_MIN_DEF,
  parameter int CALM_WINDOWS  = CALM_WINDOWS_DEF,
  parameter int ALARM_WINDOWS = ALARM_WINDOWS_DEF
) (
  input  logic       clk,
  input  logic       r,
  input  logic       stressDaalt,
  input  logic [2:0] huil,
  output logic [2:0] wiegSnelheid,
  output logic       wiegAan,
  output logic       evalPuls,
  output logic       alarm
);

  localparam logic [2:0] START_LVL_C   = 3'(START_LVL);
  localparam logic [2:0] START_SPEED_C = 3'(START_SPEED);
  localparam logic [3:0] GOOD_MIN_C    = 4'(GOOD_MIN);
  localparam logic [3:0] CALM_MAX_C    = 4'(CALM_WINDOWS);
  localparam logic [3:0] CALM_CAP_C    = 4'(CALM_WINDOWS - 1);
  localparam logic [3:0] ALARM_MAX_C   = 4'(ALARM_WINDOWS);
  localparam logic [3:0] ALARM_LAST_C  = 4'(ALARM_WINDOWS - 1);

  rockState_t state, stateNext;
  logic [2:0] speedNext;
  logic [3:0] calm, calmNext, calmInc;
  logic [3:0] alarmCnt, alarmCntNext;
  logic       alarmNext, maxDry, windowEnd, evalEdge;
  logic [3:0] pulseTotal;

  eval_timer #(
    .EVAL_CYCLES(EVAL_CYCLES)
  ) u_timer (
    .clk        (clk),
    .r          (r),
    .clear      (state == IDLE),
    .stressDaalt(stressDaalt),
    .windowEnd  (windowEnd),
    .pulseTotal (pulseTotal)
  );

  assign evalEdge = windowEnd && (state != IDLE);

  // Next state, speed, calm and alarm bookkeeping; only evaluation edges act.
  always_comb begin
    stateNext    = state;
    speedNext    = wiegSnelheid;
    calmNext     = calm;
    alarmCntNext = alarmCnt;
    alarmNext    = alarm;
    calmInc      = calm + 4'd1;
    maxDry       = (state == ROCK) && (wiegSnelheid == SPEED_MAX) && (pulseTotal == 4'd0);
    case (state)
      IDLE: begin
        speedNext = 3'd0;
        if (huil >= START_LVL_C) begin
          stateNext = ROCK;
          speedNext = START_SPEED_C;
          calmNext  = 4'd0;
        end else begin
          stateNext = IDLE;
        end
      end
      ROCK: begin
        if (!windowEnd) begin
          stateNext = ROCK;
        end else if (huil == 3'd0) begin
          if (calmInc >= CALM_MAX_C) begin
            stateNext = RAMP_DOWN;
            calmNext  = 4'd0;
          end else begin
            calmNext = calmInc;
          end
        end else begin
          // Improving windows bank calm credit, but never a full ramp-down's worth.
          if (pulseTotal >= GOOD_MIN_C) begin
            calmNext = (calmInc > CALM_CAP_C) ? CALM_CAP_C : calmInc;
          end else begin
            calmNext = 4'd0;
          end
          if ((pulseTotal == 4'd0) && (wiegSnelheid != SPEED_MAX)) begin
            speedNext = wiegSnelheid + 3'd1;
          end else begin
            speedNext = wiegSnelheid;
          end
        end
      end
      RAMP_DOWN: begin
        if (!windowEnd) begin
          stateNext = RAMP_DOWN;
        end else if (huil >= START_LVL_C) begin
          stateNext = ROCK;
        end else if (wiegSnelheid <= 3'd1) begin
          speedNext = 3'd0;
          stateNext = IDLE;
        end else begin
          speedNext = wiegSnelheid - 3'd1;
          stateNext = RAMP_DOWN;
        end
      end
      default: begin
        stateNext = IDLE;
        speedNext = 3'd0;
        calmNext  = 4'd0;
      end
    endcase
    if (evalEdge) begin
      if (maxDry) begin
        alarmCntNext = (alarmCnt >= ALARM_MAX_C) ? ALARM_MAX_C : alarmCnt + 4'd1;
      end else begin
        alarmCntNext = 4'd0;
      end
      if (huil == 3'd0) begin
        alarmNext = 1'b0;
      end else if (maxDry && (alarmCnt == ALARM_LAST_C)) begin
        alarmNext = 1'b1;
      end else begin
        alarmNext = alarm;
      end
    end else begin
      alarmCntNext = alarmCnt;
      alarmNext    = alarm;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state        <= IDLE;
      wiegSnelheid <= 3'd0;
      wiegAan      <= 1'b0;
      evalPuls     <= 1'b0;
      alarm        <= 1'b0;
      calm         <= 4'd0;
      alarmCnt     <= 4'd0;
    end else begin
      state        <= stateNext;
      wiegSnelheid <= speedNext;
      wiegAan      <= (stateNext != IDLE);
      evalPuls     <= evalEdge;
      alarm        <= alarmNext;
      calm         <= calmNext;
      alarmCnt     <= alarmCntNext;
    end
  end

endmodule

// File: tb/tb_rock_controller.sv
// Self-checking bench for rock_controller: directed scenarios followed by
// randomized stimulus, all checked every cycle against a window-level model.
module tb_rock_controller;

  localparam int WIN         = 16;
  localparam int START_LVL   = 3;
  localparam int START_SPEED = 2;
  localparam int GOOD_MIN    = 2;
  localparam int CALM_WIN    = 3;
  localparam int ALARM_WIN   = 4;
  localparam int MAX_SPEED   = 7;

  localparam int M_OFF  = 0;
  localparam int M_ROCK = 1;
  localparam int M_DOWN = 2;

  logic       clk = 1'b0;
  logic       r;
  logic       stressDaalt;
  logic [2:0] huil;
  logic [2:0] wiegSnelheid;
  logic       wiegAan;
  logic       evalPuls;
  logic       alarm;

  int tests    = 0;
  int failures = 0;

  // Reference model state
  int mMode, mPhase, mPulses, mSpeed, mCalm, mDry;
  bit mAlarm, mEval;

  always #5 clk = ~clk;

  rock_controller dut (
    .clk         (clk),
    .r           (r),
    .stressDaalt (stressDaalt),
    .huil        (huil),
    .wiegSnelheid(wiegSnelheid),
    .wiegAan     (wiegAan),
    .evalPuls    (evalPuls),
    .alarm       (alarm)
  );

  task automatic expectEq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    mMode = M_OFF; mPhase = 0; mPulses = 0; mSpeed = 0;
    mCalm = 0; mDry = 0; mAlarm = 1'b0; mEval = 1'b0;
  endtask

  // One window judgement, applied with the cry level seen at the window's last edge.
  task automatic judge(input int h);
    bit dry;
    dry = (mMode == M_ROCK) && (mSpeed == MAX_SPEED) && (mPulses == 0);
    if (h == 0) mAlarm = 1'b0;
    else if (dry && mDry == ALARM_WIN - 1) mAlarm = 1'b1;
    mDry = dry ? ((mDry + 1 > ALARM_WIN) ? ALARM_WIN : mDry + 1) : 0;
    if (mMode == M_ROCK) begin
      if (h == 0) begin
        mCalm++;
        if (mCalm >= CALM_WIN) begin mMode = M_DOWN; mCalm = 0; end
      end else begin
        mCalm = (mPulses >= GOOD_MIN) ? ((mCalm + 1 > CALM_WIN - 1) ? CALM_WIN - 1 : mCalm + 1) : 0;
        if (mPulses == 0 && mSpeed < MAX_SPEED) mSpeed++;
      end
    end else begin
      if (h >= START_LVL) mMode = M_ROCK;
      else begin
        mSpeed = (mSpeed > 0) ? mSpeed - 1 : 0;
        if (mSpeed == 0) mMode = M_OFF;
      end
    end
  endtask

  task automatic modelEdge(input bit s, input int h);
    if (mMode == M_OFF) begin
      mEval = 1'b0;
      if (h >= START_LVL) begin
        mMode = M_ROCK; mSpeed = START_SPEED; mPhase = 0; mPulses = 0; mCalm = 0;
      end
    end else begin
      mPulses = (mPulses + int'(s) > 15) ? 15 : mPulses + int'(s);
      if (mPhase == WIN - 1) begin
        mEval = 1'b1; mPhase = 0;
        judge(h);
        mPulses = 0;
      end else begin
        mEval = 1'b0; mPhase++;
      end
    end
  endtask

  task automatic checkAll(input string tag);
    expectEq({tag, ".speed"}, 8'(wiegSnelheid), 8'(mSpeed));
    expectEq({tag, ".aan"},   8'(wiegAan),      8'(mMode != M_OFF));
    expectEq({tag, ".eval"},  8'(evalPuls),     8'(mEval));
    expectEq({tag, ".alarm"}, 8'(alarm),        8'(mAlarm));
  endtask

  task automatic tick(input bit s, input int h);
    stressDaalt = s;
    huil = 3'(h);
    modelEdge(s, h);
    @(posedge clk);
    #1;
    checkAll("cyc");
  endtask

  task automatic run(input int n, input bit s, input int h);
    repeat (n) tick(s, h);
  endtask

  // Called at posedge+1: reset pulse lies strictly between clock edges.
  task automatic asyncReset();
    #3 r = 1'b0;
    modelReset();
    #1 checkAll("areset");
    expectEq("areset.speed0", 8'(wiegSnelheid), 8'd0);
    #3 r = 1'b1;
  endtask

  initial begin
    int h, chunk, prob;
    bit s;
    r = 1'b1; stressDaalt = 1'b0; huil = 3'd0;
    modelReset();
    #2 r = 1'b0;
    repeat (2) @(posedge clk);
    #1 checkAll("reset");
    #3 r = 1'b1;

    // Reset mid-rock at speed 4, then stay idle with huil=0
    tick(1'b0, 5);
    run(2 * WIN, 1'b0, 5);
    expectEq("pre_reset.speed", 8'(wiegSnelheid), 8'd4);
    run(7, 1'b0, 5);
    asyncReset();
    run(20, 1'b0, 0);
    expectEq("post_reset.aan", 8'(wiegAan), 8'd0);

    // Start and ramp-up
    tick(1'b0, 5);
    expectEq("start.speed", 8'(wiegSnelheid), 8'd2);
    expectEq("start.aan", 8'(wiegAan), 8'd1);
    for (int k = 1; k <= 5; k++) begin
      run(WIN - 1, 1'b0, 5);
      expectEq("ramp.noeval", 8'(evalPuls), 8'd0);
      tick(1'b0, 5);
      expectEq("ramp.eval", 8'(evalPuls), 8'd1);
      expectEq("ramp.speed", 8'(wiegSnelheid), 8'(2 + k));
    end

    // Alarm on 4th max-speed dry window, held, cleared by huil=0
    for (int k = 1; k <= 4; k++) begin
      run(WIN, 1'b0, 5);
      expectEq("alarm.speed", 8'(wiegSnelheid), 8'd7);
      expectEq("alarm.set", 8'(alarm), 8'(k == 4));
    end
    run(WIN, 1'b0, 5);
    expectEq("alarm.held", 8'(alarm), 8'd1);
    run(WIN - 1, 1'b0, 0);
    expectEq("alarm.midwin", 8'(alarm), 8'd1);
    tick(1'b0, 0);
    expectEq("alarm.clear", 8'(alarm), 8'd0);

    // Hold on improvement: pulse on the last window cycle
    asyncReset();
    tick(1'b0, 4);
    run(2 * WIN, 1'b0, 4);
    expectEq("hold.pre", 8'(wiegSnelheid), 8'd4);
    run(WIN - 1, 1'b0, 4);
    tick(1'b1, 4);
    expectEq("hold.eval", 8'(evalPuls), 8'd1);
    expectEq("hold.speed", 8'(wiegSnelheid), 8'd4);

    // Ramp-down to speed 2, then re-trigger back into ROCK
    run(3 * WIN, 1'b0, 0);
    run(2 * WIN, 1'b0, 0);
    expectEq("down.speed2", 8'(wiegSnelheid), 8'd2);
    run(WIN - 1, 1'b0, 0);
    tick(1'b0, 6);
    expectEq("retrig.speed", 8'(wiegSnelheid), 8'd2);
    expectEq("retrig.aan", 8'(wiegAan), 8'd1);
    run(WIN, 1'b0, 6);
    expectEq("retrig.rock", 8'(wiegSnelheid), 8'd3);

    // Calm down from speed 3
    run(3 * WIN, 1'b0, 0);
    expectEq("calm.speed", 8'(wiegSnelheid), 8'd3);
    for (int k = 1; k <= 3; k++) begin
      run(WIN, 1'b0, 0);
      expectEq("calm.step", 8'(wiegSnelheid), 8'(3 - k));
      expectEq("calm.aan", 8'(wiegAan), 8'(k != 3));
    end

    // Improvement shortcut: banked calm plus one quiet window
    tick(1'b0, 5);
    repeat (3) begin
      run(WIN - 2, 1'b0, 5);
      run(2, 1'b1, 5);
    end
    run(WIN, 1'b0, 0);
    run(WIN, 1'b0, 0);
    expectEq("shortcut.speed", 8'(wiegSnelheid), 8'd1);

    // Randomized chunks
    for (int w = 0; w < 300; w++) begin
      h = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 7));
      chunk = $urandom_range(1, 24);
      prob = $urandom_range(0, 3);
      for (int c = 0; c < chunk; c++) begin
        s = (prob == 0) ? 1'b0 : ($urandom_range(0, 7) < prob * 2);
        tick(s, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : h);
      end
      if ($urandom_range(0, 60) == 0) asyncReset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
